// File: rtl/mem_access_unit_if.sv
// Request/response handshake and data_memory port of the load/store front-end.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        memread;
    logic        memwrite;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Unit side: serves requests, drives the memory port.
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, memread, memwrite, mem_address,
        mem_wdata
    );

    // Environment side: execute stage plus data_memory.
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, memread, memwrite, mem_address,
        mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front-end for a word-only data_memory: sub-word stores via
// read-modify-write, sub-word loads with sign/zero extension. One request in flight.
module mem_access_unit #(
    parameter int unsigned MEM_WORDS = 32,
    parameter int unsigned IDX_W     = 5
) (
    input logic              clk,
    input logic              rst_n,
    mem_access_unit_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StRd, StCap, StMerge, StWr, StResp} state_e;

    localparam logic [1:0]  SzByte    = 2'b00;
    localparam logic [1:0]  SzHalf    = 2'b01;
    localparam logic [1:0]  SzWord    = 2'b10;
    localparam logic [31:0] AddrLimit = 32'(4 * MEM_WORDS);

    state_e             state_q, state_d;
    logic               we_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic [IDX_W+1:0]   addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        merge_q;
    logic [31:0]        rsp_rdata_q;
    logic               rsp_err_q;

    logic               accept;
    logic               req_err;
    logic [4:0]         shamt;
    logic [31:0]        mem_index;
    logic [31:0]        rd_shifted;
    logic [31:0]        load_ext;
    logic [31:0]        lane_mask;
    logic [31:0]        merge_d;
    logic               req_ready;
    logic               memread;
    logic               memwrite;
    logic [31:0]        mem_address;
    logic [31:0]        mem_wdata;
    logic               rsp_valid;

    assign accept    = bus.req_valid && (state_q == StIdle);
    assign shamt     = {addr_q[1:0], 3'b000};
    assign mem_index = {{(32 - IDX_W){1'b0}}, addr_q[IDX_W+1:2]};

    // Reject illegal size, misalignment and out-of-range addresses before touching memory.
    always_comb begin
        req_err = (bus.req_size == 2'b11)
                | ((bus.req_size == SzHalf) && bus.req_addr[0])
                | ((bus.req_size == SzWord) && (bus.req_addr[1:0] != 2'b00))
                | (bus.req_addr >= AddrLimit);
    end

    // Lane alignment: extend the addressed lane for loads, splice it in for stores.
    always_comb begin
        rd_shifted = bus.mem_rdata >> shamt;
        load_ext   = rd_shifted;
        lane_mask  = 32'hFFFF_FFFF;
        case (size_q)
            SzByte: begin
                load_ext  = uns_q ? {24'h0, rd_shifted[7:0]}
                                  : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
                lane_mask = 32'h0000_00FF;
            end
            SzHalf: begin
                load_ext  = uns_q ? {16'h0, rd_shifted[15:0]}
                                  : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
                lane_mask = 32'h0000_FFFF;
            end
            default: ;
        endcase
        merge_d = (bus.mem_rdata & ~(lane_mask << shamt)) | ((wdata_q & lane_mask) << shamt);
    end

    // Next state and state-decoded outputs; memory port is zero outside RD/WR.
    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        mem_address = 32'h0;
        mem_wdata   = 32'h0;
        rsp_valid   = 1'b0;
        case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (req_err) begin
                        state_d = StResp;
                    end else if (bus.req_we && (bus.req_size == SzWord)) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                memread     = 1'b1;
                mem_address = mem_index;
                state_d     = we_q ? StMerge : StCap;
            end
            StCap:   state_d = StResp;
            StMerge: state_d = StWr;
            StWr: begin
                memwrite    = 1'b1;
                mem_address = mem_index;
                mem_wdata   = (size_q == SzWord) ? wdata_q : merge_q;
                state_d     = StResp;
            end
            StResp: begin
                rsp_valid = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Capture request fields on accept; they stay put for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            addr_q  <= bus.req_addr[IDX_W+1:0];
            wdata_q <= bus.req_wdata;
        end
    end

    // Merged word for sub-word stores, built from the read-back data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 merge_q <= 32'h0;
        else if (state_q == StMerge) merge_q <= merge_d;
    end

    // Response registers update only on entry to RESP and hold until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else if (state_d == StResp) begin
            rsp_err_q   <= (state_q == StIdle);
            rsp_rdata_q <= (state_q == StCap) ? load_ext : 32'h0;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.memread     = memread;
    assign bus.memwrite    = memwrite;
    assign bus.mem_address = mem_address;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
endmodule
